// File: rtl/motor_speed_loop_ctrl.sv
// motor_speed_loop_ctrl
// Closed-loop motor speed controller. Once per loop period it samples the
// target and measured RPM, runs a shift-gain PI update with integrator
// anti-windup, and publishes a clamped PWM duty word with a one-cycle strobe.
// Repeated high-duty loops while the motor reads zero speed latch a stall fault.

module motor_speed_loop_ctrl #(
    parameter int LOOP_PERIOD_CYCLES = 1250000,
    parameter int KP_SHIFT           = 2,
    parameter int KI_SHIFT           = 4,
    parameter int INTEG_LIMIT        = 4096,
    parameter int STALL_DUTY         = 256,
    parameter int STALL_LOOPS        = 3
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       enable_in,
    input  logic [9:0] target_rpm_in,
    input  logic [9:0] actual_rpm_in,
    output logic [9:0] duty_out,
    output logic       duty_valid_out,
    output logic       fault_out
);

    // Period counter sized to hold LOOP_PERIOD_CYCLES-1.
    localparam int CNT_W = (LOOP_PERIOD_CYCLES > 1) ? $clog2(LOOP_PERIOD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_WRAP = CNT_W'(LOOP_PERIOD_CYCLES - 1);

    // Stall counter only needs to reach STALL_LOOPS before the fault trips.
    localparam int STALL_W = (STALL_LOOPS > 0) ? $clog2(STALL_LOOPS + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_TRIP = STALL_W'(STALL_LOOPS);

    // Integrator bounds, kept one bit wider than the integrator so the
    // unsaturated sum can be compared without overflow.
    localparam logic signed [16:0] INTEG_MAX = 17'(INTEG_LIMIT);
    localparam logic signed [16:0] INTEG_MIN = 17'(-INTEG_LIMIT);

    localparam logic signed [19:0] DUTY_MAX     = 20'sd1023;
    localparam logic        [10:0] STALL_DUTY_W = 11'(STALL_DUTY);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_INTEG  = 3'd3,
        ST_OUTPUT = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic signed [10:0]  err_q,       err_d;
    logic [9:0]          target_q,    target_d;
    logic [9:0]          actual_q,    actual_d;
    logic signed [15:0]  integ_q,     integ_d;
    logic                sat_hi_q,    sat_hi_d;
    logic                sat_lo_q,    sat_lo_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [9:0]          duty_q,      duty_d;
    logic                duty_valid_q, duty_valid_d;
    logic                fault_q,     fault_d;

    // Datapath intermediates
    logic [CNT_W-1:0]    cnt_inc;
    logic signed [16:0]  integ_wide;
    logic signed [15:0]  integ_sat;
    logic                err_pos;
    logic                err_neg;
    logic                integ_hold;
    logic signed [19:0]  prop_ext;
    logic signed [19:0]  prop_term;
    logic signed [19:0]  int_ext;
    logic signed [19:0]  int_term;
    logic signed [19:0]  pi_sum;
    logic [9:0]          duty_clamped;
    logic                clamp_hi;
    logic                clamp_lo;
    logic                stall_hit;
    logic [STALL_W-1:0]  stall_inc;
    logic                stall_trip;
    logic                leave_to_idle;

    // Free-running loop period counter value for the next cycle, wrapping so the period is exact.
    always_comb begin
        cnt_inc = (cnt_q == CNT_WRAP) ? '0 : cnt_q + 1'b1;
    end

    // Integrator candidate: add the latched error and saturate to the symmetric limit;
    // anti-windup holds the integrator when last loop's output clamped in the error's direction.
    always_comb begin
        integ_wide = {integ_q[15], integ_q} + {{6{err_q[10]}}, err_q};
        if (integ_wide > INTEG_MAX) begin
            integ_sat = INTEG_MAX[15:0];
        end else if (integ_wide < INTEG_MIN) begin
            integ_sat = INTEG_MIN[15:0];
        end else begin
            integ_sat = integ_wide[15:0];
        end
        err_pos    = !err_q[10] && (err_q != '0);
        err_neg    = err_q[10];
        integ_hold = (sat_hi_q && err_pos) || (sat_lo_q && err_neg);
    end

    // PI sum with arithmetic shifts (integral term floors toward minus infinity), then clamp to the duty range.
    always_comb begin
        prop_ext     = {{9{err_q[10]}}, err_q};
        prop_term    = prop_ext <<< KP_SHIFT;
        int_ext      = {{4{integ_q[15]}}, integ_q};
        int_term     = int_ext >>> KI_SHIFT;
        pi_sum       = prop_term + int_term;
        duty_clamped = pi_sum[9:0];
        clamp_hi     = 1'b0;
        clamp_lo     = 1'b0;
        if (pi_sum[19]) begin
            duty_clamped = '0;
            clamp_lo     = 1'b1;
        end else if (pi_sum > DUTY_MAX) begin
            duty_clamped = 10'd1023;
            clamp_hi     = 1'b1;
        end
    end

    // Stall detection: driving hard while the tachometer reads zero speed.
    always_comb begin
        stall_hit  = (actual_q == '0) && (target_q != '0) &&
                     ({1'b0, duty_clamped} >= STALL_DUTY_W);
        stall_inc  = stall_cnt_q + 1'b1;
        stall_trip = stall_hit && (stall_inc == STALL_TRIP);
    end

    // Sequencer: next state and next register values; dropping enable abandons any in-flight loop.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        target_d     = target_q;
        actual_d     = actual_q;
        integ_d      = integ_q;
        sat_hi_d     = sat_hi_q;
        sat_lo_d     = sat_lo_q;
        stall_cnt_d  = stall_cnt_q;
        duty_d       = duty_q;
        duty_valid_d = 1'b0;
        fault_d      = fault_q;

        leave_to_idle = (state_q != ST_IDLE) && !enable_in;

        if ((state_q == ST_IDLE) || leave_to_idle) begin
            cnt_d       = '0;
            err_d       = '0;
            target_d    = '0;
            actual_d    = '0;
            integ_d     = '0;
            sat_hi_d    = 1'b0;
            sat_lo_d    = 1'b0;
            stall_cnt_d = '0;
            duty_d      = '0;
            fault_d     = 1'b0;
            state_d     = ((state_q == ST_IDLE) && enable_in) ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_WRAP) begin
                        state_d = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    cnt_d    = cnt_inc;
                    target_d = target_rpm_in;
                    actual_d = actual_rpm_in;
                    err_d    = $signed({1'b0, target_rpm_in}) - $signed({1'b0, actual_rpm_in});
                    state_d  = ST_INTEG;
                end
                ST_INTEG: begin
                    cnt_d = cnt_inc;
                    if (!integ_hold) begin
                        integ_d = integ_sat;
                    end
                    state_d = ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    cnt_d    = cnt_inc;
                    sat_hi_d = clamp_hi;
                    sat_lo_d = clamp_lo;
                    if (stall_trip) begin
                        stall_cnt_d = '0;
                        integ_d     = '0;
                        duty_d      = '0;
                        fault_d     = 1'b1;
                        state_d     = ST_FAULT;
                    end else begin
                        stall_cnt_d  = stall_hit ? stall_inc : '0;
                        duty_d       = duty_clamped;
                        duty_valid_d = 1'b1;
                        state_d      = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    cnt_d   = '0;
                    integ_d = '0;
                    duty_d  = '0;
                    fault_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            err_q        <= '0;
            target_q     <= '0;
            actual_q     <= '0;
            integ_q      <= '0;
            sat_hi_q     <= 1'b0;
            sat_lo_q     <= 1'b0;
            stall_cnt_q  <= '0;
            duty_q       <= '0;
            duty_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            target_q     <= target_d;
            actual_q     <= actual_d;
            integ_q      <= integ_d;
            sat_hi_q     <= sat_hi_d;
            sat_lo_q     <= sat_lo_d;
            stall_cnt_q  <= stall_cnt_d;
            duty_q       <= duty_d;
            duty_valid_q <= duty_valid_d;
            fault_q      <= fault_d;
        end
    end

    assign duty_out       = duty_q;
    assign duty_valid_out = duty_valid_q;
    assign fault_out      = fault_q;

endmodule

// File: tb/tb_motor_speed_loop_ctrl.sv
// tb_motor_speed_loop_ctrl
// Self-checking bench: directed scenarios plus randomized loops, checked against
// a per-loop arithmetic model of the PI controller and stall detector.

module tb_motor_speed_loop_ctrl;

    localparam int LOOP   = 16;
    localparam int KP     = 2;
    localparam int KI     = 4;
    localparam int LIM    = 4096;
    localparam int SDUTY  = 256;
    localparam int SLOOPS = 3;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       enable_in;
    logic [9:0] target_rpm_in;
    logic [9:0] actual_rpm_in;
    logic [9:0] duty_out;
    logic       duty_valid_out;
    logic       fault_out;

    int errors = 0;
    int checks = 0;

    // Reference model state, one update per control loop
    int m_integ;
    bit m_sat_hi;
    bit m_sat_lo;
    int m_stall;

    motor_speed_loop_ctrl #(
        .LOOP_PERIOD_CYCLES (LOOP),
        .KP_SHIFT           (KP),
        .KI_SHIFT           (KI),
        .INTEG_LIMIT        (LIM),
        .STALL_DUTY         (SDUTY),
        .STALL_LOOPS        (SLOOPS)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .enable_in      (enable_in),
        .target_rpm_in  (target_rpm_in),
        .actual_rpm_in  (actual_rpm_in),
        .duty_out       (duty_out),
        .duty_valid_out (duty_valid_out),
        .fault_out      (fault_out)
    );

    // 100 MHz bench clock
    always #5 clk_in = ~clk_in;

    function automatic int floor_div(input int x, input int d);
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic int clamp(input int x, input int lo, input int hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    task automatic model_clear();
        m_integ  = 0;
        m_sat_hi = 0;
        m_sat_lo = 0;
        m_stall  = 0;
    endtask

    // One control loop of the reference model: integer PI law, anti-windup, clamp, stall count
    task automatic model_loop(input int t, input int a, output int duty, output bit trip);
        int err;
        int sum;
        err = t - a;
        if (!((m_sat_hi && err > 0) || (m_sat_lo && err < 0)))
            m_integ = clamp(m_integ + err, -LIM, LIM);
        sum      = err * (2 ** KP) + floor_div(m_integ, 2 ** KI);
        m_sat_hi = (sum > 1023);
        m_sat_lo = (sum < 0);
        duty     = clamp(sum, 0, 1023);
        if (a == 0 && t != 0 && duty >= SDUTY) m_stall++;
        else m_stall = 0;
        trip = (m_stall >= SLOOPS);
        if (trip) duty = 0;
    endtask

    // Run one loop: apply inputs, wait for the pulse wait_n negedges later, check it.
    // plan_duty >= 0 adds a check against a known scenario value.
    task automatic check_loop(input int t, input int a, input int wait_n, input bit scramble,
                              input int plan_duty, input string tag, output bit tripped);
        int exp_duty;
        bit trip;
        bit seen;
        int k;
        target_rpm_in = 10'(t);
        actual_rpm_in = 10'(a);
        model_loop(t, a, exp_duty, trip);
        tripped = trip;
        seen = 0;
        k = 0;
        while (!seen && k < wait_n + 4) begin
            @(negedge clk_in);
            k++;
            if (scramble && k == wait_n - 2) begin
                target_rpm_in = 10'($urandom_range(0, 1023));
                actual_rpm_in = 10'($urandom_range(0, 1023));
            end
            if (duty_valid_out === 1'b1) seen = 1;
        end
        if (trip) begin
            checks++;
            if (seen) $display("[TB] FAIL %s no_valid_on_fault: valid seen at cycle %0d, expected none", tag, k);
            checks++;
            if (fault_out !== 1'b1) $display("[TB] FAIL %s fault_set: got %b expected 1", tag, fault_out);
            checks++;
            if (duty_out !== 10'd0) $display("[TB] FAIL %s fault_duty: got %0d expected 0", tag, duty_out);
            if (seen || fault_out !== 1'b1 || duty_out !== 10'd0) errors++;
        end else begin
            checks++;
            if (!seen || k != wait_n) begin
                errors++;
                $display("[TB] FAIL %s valid_timing: seen=%0b after %0d cycles, expected after %0d", tag, seen, k, wait_n);
            end
            checks++;
            if (duty_out !== 10'(exp_duty)) begin
                errors++;
                $display("[TB] FAIL %s duty: got %0d expected %0d", tag, duty_out, exp_duty);
            end
            if (plan_duty >= 0) begin
                checks++;
                if (duty_out !== 10'(plan_duty)) begin
                    errors++;
                    $display("[TB] FAIL %s plan_duty: got %0d expected %0d", tag, duty_out, plan_duty);
                end
            end
            checks++;
            if (fault_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s fault_clear: got %b expected 0", tag, fault_out);
            end
            @(negedge clk_in);
            checks++;
            if (duty_valid_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s valid_width: got %b expected 0", tag, duty_valid_out);
            end
            checks++;
            if (duty_out !== 10'(exp_duty)) begin
                errors++;
                $display("[TB] FAIL %s duty_hold: got %0d expected %0d", tag, duty_out, exp_duty);
            end
        end
    endtask

    // Drop enable and confirm outputs return to idle values on the next cycle
    task automatic go_idle(input string tag);
        enable_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if (duty_out !== 10'd0) begin
            errors++;
            $display("[TB] FAIL %s idle_duty: got %0d expected 0", tag, duty_out);
        end
        checks++;
        if (duty_valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s idle_valid: got %b expected 0", tag, duty_valid_out);
        end
        checks++;
        if (fault_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s idle_fault: got %b expected 0", tag, fault_out);
        end
        model_clear();
    endtask

    task automatic test_reset();
        bit tr;
        checks++;
        if (duty_out !== 10'd0 || duty_valid_out !== 1'b0 || fault_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: duty=%0d valid=%b fault=%b expected 0/0/0", duty_out, duty_valid_out, fault_out);
        end
        reset_in = 1'b0;
        target_rpm_in = 10'd200;
        actual_rpm_in = 10'd100;
        @(negedge clk_in);
        enable_in = 1'b1;
        model_clear();
        check_loop(200, 100, LOOP + 4, 0, 406, "reset_pre", tr);
        // After the width check we sit one cycle past the pulse; INTEG is 13 cycles later
        repeat (13) @(negedge clk_in);
        checks++;
        if (duty_out !== 10'd406) begin
            errors++;
            $display("[TB] FAIL reset_hold_before: got %0d expected 406", duty_out);
        end
        #1 reset_in = 1'b1;
        #1;
        checks++;
        if (duty_out !== 10'd0 || duty_valid_out !== 1'b0 || fault_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_midloop: duty=%0d valid=%b fault=%b expected 0/0/0", duty_out, duty_valid_out, fault_out);
        end
        @(negedge clk_in);
        reset_in = 1'b0;
        model_clear();
        check_loop(200, 100, LOOP + 4, 0, 406, "reset_post", tr);
        go_idle("reset");
    endtask

    task automatic test_zero_error();
        bit tr;
        enable_in = 1'b1;
        check_loop(100, 100, LOOP + 4, 0, 0, "zero_l1", tr);
        check_loop(100, 100, LOOP - 1, 0, 0, "zero_l2", tr);
        check_loop(100, 100, LOOP - 1, 0, 0, "zero_l3", tr);
        go_idle("zero");
    endtask

    task automatic test_positive_error();
        bit tr;
        enable_in = 1'b1;
        check_loop(200, 100, LOOP + 4, 0, 406, "pos_l1", tr);
        check_loop(200, 100, LOOP - 1, 0, 412, "pos_l2", tr);
        go_idle("pos");
    endtask

    task automatic test_negative_error();
        bit tr;
        enable_in = 1'b1;
        check_loop(100, 300, LOOP + 4, 0, 0, "neg_l1", tr);
        check_loop(100, 300, LOOP - 1, 0, 0, "neg_l2", tr);
        // Integrator held at -200, so err=+50 gives 200 + floor(-150/16) = 190
        check_loop(150, 100, LOOP - 1, 0, 190, "neg_l3", tr);
        go_idle("neg");
    endtask

    task automatic test_stall();
        bit tr;
        enable_in = 1'b1;
        check_loop(1023, 0, LOOP + 4, 0, 1023, "stall_l1", tr);
        check_loop(1023, 0, LOOP - 1, 0, 1023, "stall_l2", tr);
        check_loop(1023, 0, LOOP - 1, 0, -1, "stall_l3", tr);
        checks++;
        if (!tr) begin
            errors++;
            $display("[TB] FAIL stall_model_trip: got %b expected 1", tr);
        end
        go_idle("stall");
    endtask

    task automatic test_enable_drop();
        bit tr;
        int seen;
        enable_in = 1'b1;
        check_loop(200, 100, LOOP + 4, 0, 406, "drop_l1", tr);
        // SAMPLE is 12 cycles after the post-pulse cycle
        repeat (12) @(negedge clk_in);
        enable_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if (duty_out !== 10'd0 || duty_valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_idle: duty=%0d valid=%b expected 0/0", duty_out, duty_valid_out);
        end
        seen = 0;
        repeat (LOOP + 4) begin
            @(negedge clk_in);
            if (duty_valid_out === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL drop_no_valid: got %0d pulses expected 0", seen);
        end
        model_clear();
        enable_in = 1'b1;
        check_loop(200, 100, LOOP + 4, 0, 406, "drop_restart", tr);
        go_idle("drop");
    endtask

    task automatic test_random();
        bit tr;
        bit first;
        int t;
        int a;
        enable_in = 1'b1;
        first = 1;
        for (int i = 0; i < 24; i++) begin
            t = int'($urandom_range(0, 1023));
            a = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 1023));
            check_loop(t, a, first ? LOOP + 4 : LOOP - 1, 1, -1, $sformatf("rand_%0d", i), tr);
            if (tr) begin
                go_idle("rand_fault");
                enable_in = 1'b1;
                first = 1;
            end else begin
                first = 0;
            end
        end
        go_idle("rand");
    endtask

    initial begin
        reset_in      = 1'b1;
        enable_in     = 1'b0;
        target_rpm_in = 10'd0;
        actual_rpm_in = 10'd0;
        model_clear();
        repeat (3) @(negedge clk_in);
        test_reset();
        test_zero_error();
        test_positive_error();
        test_negative_error();
        test_stall();
        test_enable_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motor_speed_loop_ctrl.md
# motor_speed_loop_ctrl

Closed-loop speed controller that sequences the tachometer measurement and the motor PWM duty. A fixed-period loop tick latches the measured RPM and the target RPM, runs a shift-gain PI update with integrator anti-windup and output clamping, and publishes a new duty word with a one-cycle valid strobe. Stall protection latches a fault after repeated high-duty, zero-speed loops. It sits between the tachometer interface (`actual_rpm_out`) and the PWM generator.

## Interface
- LOOP_PERIOD_CYCLES, 1250000, loop period in clk cycles (10 ms at 125 MHz); legal minimum 8
- KP_SHIFT, 2, proportional gain = 2^KP_SHIFT
- KI_SHIFT, 4, integral gain = 2^-KI_SHIFT
- INTEG_LIMIT, 4096, integrator saturates to ±INTEG_LIMIT
- STALL_DUTY, 256, duty at or above which a zero-speed loop counts as a stall
- STALL_LOOPS, 3, consecutive stall loops that trip the fault
- clk_in  in  1  single clock
- reset_in  in  1  asynchronous, active-high reset
- enable_in  in  1  level; high runs the loop, low forces IDLE
- target_rpm_in  in  10  commanded speed, unsigned
- actual_rpm_in  in  10  measured speed from the tachometer interface, unsigned
- duty_out  out  10  PWM duty, 0..1023
- duty_valid_out  out  1  one-cycle strobe, duty_out updated
- fault_out  out  1  stall fault, latched

## Operation
- States: IDLE, RUN, SAMPLE, INTEG, OUTPUT, FAULT.
- IDLE: period counter = 0, integrator = 0, stall count = 0, sat_hi/sat_lo flags = 0, duty_out = 0, fault_out = 0. enable_in high → RUN.
- Period counter increments every cycle outside IDLE/FAULT and wraps at LOOP_PERIOD_CYCLES-1. It keeps running through SAMPLE/INTEG/OUTPUT, so the loop period is exact.
- RUN: on the wrap cycle → SAMPLE.
- SAMPLE: latch err = target − actual as signed 11-bit → INTEG.
- INTEG: integ_next = sat(integ + err, ±INTEG_LIMIT), 16-bit signed. Skip the update if (sat_hi && err>0) or (sat_lo && err<0); the flags come from the previous loop → OUTPUT.
- OUTPUT:
  - sum = (err <<< KP_SHIFT) + (integ >>> KI_SHIFT), arithmetic shift rounding toward −∞, ≥20-bit signed.
  - Clamp sum to 0..1023. Set sat_hi if clamped high and sat_lo if clamped low.
  - Register duty_out and pulse duty_valid_out → RUN.
- Stall: evaluated in OUTPUT.
  - If latched actual == 0, target != 0 and new duty ≥ STALL_DUTY, increment stall count; otherwise clear it.
  - When the count reaches STALL_LOOPS → FAULT instead of RUN. That OUTPUT cycle issues no duty_valid pulse and duty_out is driven to 0.
- FAULT: fault_out = 1, duty_out = 0, integrator cleared, no valid pulses. Only exit is enable_in low → IDLE, which clears fault_out.
- enable_in low in any non-IDLE state → IDLE on the next edge. Any in-flight update is discarded and no valid pulse is issued.

## Timing
- Reset values: duty_out = 0, duty_valid_out = 0, fault_out = 0; state IDLE.
- reset_in assertion clears all registers immediately, at any point in the loop.
- The period counter is 0 on the first RUN cycle.
- If wrap occurs at cycle W, SAMPLE is at W+1, INTEG at W+2 and OUTPUT at W+3. duty_out and duty_valid_out are visible from W+4, with valid high for exactly one cycle.
- First valid after enable: LOOP_PERIOD_CYCLES+3 cycles after the first RUN cycle. After that, valid pulses repeat every LOOP_PERIOD_CYCLES.
- Inputs are sampled only in SAMPLE; changes at other times have no effect until the next loop.
- duty_out holds between valid pulses.

## Test plan
Parameters for all scenarios: LOOP_PERIOD_CYCLES=16, KP_SHIFT=2, KI_SHIFT=4, INTEG_LIMIT=4096, STALL_DUTY=256, STALL_LOOPS=3.
- Reset mid-loop (assert reset_in while state=INTEG) → all outputs 0 within the same cycle. After release with enable high, the first valid pulse arrives 19 cycles after the first RUN cycle.
- Zero error: target=100, actual=100 → duty_out=0 with valid pulses exactly 16 cycles apart and fault_out=0.
- Positive error: target=200, actual=100 → duty_out=406 on loop 1 (400+6) and 412 on loop 2 (400+12).
- Negative error: target=100, actual=300 → sum = −800 + (−13) → duty_out=0. sat_lo is set, and on loop 2 the integrator holds at −200.
- Saturation and stall: target=1023, actual=0 → loop 1 duty_out=1023 with integ=1023. On loop 2 the integrator holds at 1023 (anti-windup). On loop 3 fault_out=1, duty_out=0 and valid pulses stop. Drop enable_in → fault_out=0 next cycle.
- Enable drop: deassert enable_in in the SAMPLE cycle → no valid pulse that loop, duty_out=0 next cycle, state IDLE.
